// File: rtl/ycbcr422_rgb565.sv
// YCbCr 4:2:2 byte stream (YUYV or UYVY) to RGB565 decoder with a 4-stage pipeline.
// Frame sync and line valid are delayed 5 clk to stay aligned with the pixel output.
module ycbcr422_rgb565 #(
  parameter int BYTE_ORDER = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       per_frame_vsync,
  input  logic       per_frame_href,
  input  logic       per_frame_clken,
  input  logic [7:0] per_img_data,
  output logic       post_frame_vsync,
  output logic       post_frame_href,
  output logic       post_frame_clken,
  output logic [4:0] post_img_red,
  output logic [5:0] post_img_green,
  output logic [4:0] post_img_blue
);

  logic [1:0] phase;
  logic       vsync_d;
  logic [7:0] y0_q, cb_q, y1_q, cr_q;
  logic       pending;
  logic       accept, vsync_rise, group_done;

  assign accept     = per_frame_clken & per_frame_href;
  assign vsync_rise = per_frame_vsync & ~vsync_d;
  assign group_done = accept & (phase == 2'd3) & ~vsync_rise & ~pending;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase   <= '0;
      vsync_d <= 1'b0;
      pending <= 1'b0;
      y0_q    <= '0;
      cb_q    <= '0;
      y1_q    <= '0;
      cr_q    <= '0;
    end else begin
      vsync_d <= per_frame_vsync;
      pending <= group_done;
      if (!per_frame_href || vsync_rise) phase <= '0;
      else if (accept)                   phase <= phase + 2'd1;
      if (accept) begin
        if (BYTE_ORDER == 0) begin
          case (phase)
            2'd0:    y0_q <= per_img_data;
            2'd1:    cb_q <= per_img_data;
            2'd2:    y1_q <= per_img_data;
            default: cr_q <= per_img_data;
          endcase
        end else begin
          case (phase)
            2'd0:    cb_q <= per_img_data;
            2'd1:    y0_q <= per_img_data;
            2'd2:    cr_q <= per_img_data;
            default: y1_q <= per_img_data;
          endcase
        end
      end
    end
  end

  // Pixel0 takes the group's last byte straight from the bus; pixel1 uses the held copy.
  logic [7:0] op_y, op_cb, op_cr;
  always_comb begin
    op_y  = y1_q;
    op_cb = cb_q;
    op_cr = cr_q;
    if (group_done) begin
      op_y = y0_q;
      if (BYTE_ORDER == 0) op_cr = per_img_data;
    end
  end

  // S0 operands
  logic              s0_valid;
  logic [7:0]        s0_y;
  logic signed [8:0] s0_dcb, s0_dcr;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s0_valid <= 1'b0;
      s0_y     <= '0;
      s0_dcb   <= '0;
      s0_dcr   <= '0;
    end else begin
      s0_valid <= group_done | pending;
      if (group_done | pending) begin
        s0_y   <= op_y;
        s0_dcb <= $signed({1'b0, op_cb} - 9'd128);
        s0_dcr <= $signed({1'b0, op_cr} - 9'd128);
      end
    end
  end

  // S1 products, S2 sums
  logic signed [17:0] dcb_x, dcr_x;
  assign dcb_x = {{9{s0_dcb[8]}}, s0_dcb};
  assign dcr_x = {{9{s0_dcr[8]}}, s0_dcr};

  logic               s1_valid, s2_valid;
  logic signed [17:0] s1_y, s1_r, s1_gb, s1_gr, s1_b;
  logic signed [17:0] s2_r, s2_g, s2_b;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_y     <= '0;
      s1_r     <= '0;
      s1_gb    <= '0;
      s1_gr    <= '0;
      s1_b     <= '0;
      s2_valid <= 1'b0;
      s2_r     <= '0;
      s2_g     <= '0;
      s2_b     <= '0;
    end else begin
      s1_valid <= s0_valid;
      s1_y     <= $signed({2'b00, s0_y, 8'h00});
      s1_r     <= 18'sd359 * dcr_x;
      s1_gb    <= 18'sd88 * dcb_x;
      s1_gr    <= 18'sd183 * dcr_x;
      s1_b     <= 18'sd454 * dcb_x;
      s2_valid <= s1_valid;
      s2_r     <= s1_y + s1_r;
      s2_g     <= s1_y - s1_gb - s1_gr;
      s2_b     <= s1_y + s1_b;
    end
  end

  // Floor shift by 8 then clamp to 0..255: sign bit -> 0, bit 16 set -> 255.
  function automatic logic [7:0] sat8(input logic signed [17:0] s);
    if (s[17])      sat8 = 8'd0;
    else if (s[16]) sat8 = 8'd255;
    else            sat8 = s[15:8];
  endfunction

  logic [4:0] vs_sr, hr_sr;
  logic [7:0] r8, g8, b8;
  assign r8 = sat8(s2_r);
  assign g8 = sat8(s2_g);
  assign b8 = sat8(s2_b);

  // S3 pack; hr_sr[3] is next cycle's post_frame_href, used to blank RGB outside the line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vs_sr            <= '0;
      hr_sr            <= '0;
      post_frame_clken <= 1'b0;
      post_img_red     <= '0;
      post_img_green   <= '0;
      post_img_blue    <= '0;
    end else begin
      vs_sr            <= {vs_sr[3:0], per_frame_vsync};
      hr_sr            <= {hr_sr[3:0], per_frame_href};
      post_frame_clken <= s2_valid;
      if (!hr_sr[3]) begin
        post_img_red   <= '0;
        post_img_green <= '0;
        post_img_blue  <= '0;
      end else if (s2_valid) begin
        post_img_red   <= r8[7:3];
        post_img_green <= g8[7:2];
        post_img_blue  <= b8[7:3];
      end
    end
  end

  assign post_frame_vsync = vs_sr[4];
  assign post_frame_href  = hr_sr[4];

endmodule

// File: tb/tb_ycbcr422_rgb565.sv
// Directed bench for ycbcr422_rgb565: YUYV instance checked via scoreboard and cycle history,
// UYVY instance used for byte order and mid-pixel-pair reset.
module tb_ycbcr422_rgb565;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       vs = 1'b0, hr = 1'b0, ce = 1'b0;
  logic [7:0] d = 8'd0;

  logic       o0_vs, o0_hr, o0_ce;
  logic [4:0] o0_r, o0_b;
  logic [5:0] o0_g;
  logic       o1_vs, o1_hr, o1_ce;
  logic [4:0] o1_r, o1_b;
  logic [5:0] o1_g;

  ycbcr422_rgb565 #(.BYTE_ORDER(0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(d),
    .post_frame_vsync(o0_vs), .post_frame_href(o0_hr), .post_frame_clken(o0_ce),
    .post_img_red(o0_r), .post_img_green(o0_g), .post_img_blue(o0_b)
  );

  ycbcr422_rgb565 #(.BYTE_ORDER(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .per_frame_vsync(vs), .per_frame_href(hr), .per_frame_clken(ce), .per_img_data(d),
    .post_frame_vsync(o1_vs), .post_frame_href(o1_hr), .post_frame_clken(o1_ce),
    .post_img_red(o1_r), .post_img_green(o1_g), .post_img_blue(o1_b)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int HN = 2048;
  logic [15:0] rgb0_h [HN];
  logic [15:0] rgb1_h [HN];
  logic        ce0_h  [HN];
  logic        ce1_h  [HN];
  logic        hr0_h  [HN];
  logic        vs0_h  [HN];
  logic        in_vs_h[HN];

  // scoreboard
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          got_cyc_q[$];
  int          errors = 0;
  int          checks = 0;

  always @(negedge clk) begin
    if (cyc < HN) begin
      rgb0_h[cyc]  = {o0_r, o0_g, o0_b};
      rgb1_h[cyc]  = {o1_r, o1_g, o1_b};
      ce0_h[cyc]   = o0_ce;
      ce1_h[cyc]   = o1_ce;
      hr0_h[cyc]   = o0_hr;
      vs0_h[cyc]   = o0_vs;
      in_vs_h[cyc] = vs;
    end
    if (o0_ce) begin
      got_q.push_back({o0_r, o0_g, o0_b});
      got_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h exp=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] px(input int r, input int g, input int b);
    return {r[4:0], g[5:0], b[4:0]};
  endfunction

  // driver tasks: each step holds the inputs for exactly one cycle
  task automatic step(input logic h, input logic c, input logic [7:0] b);
    hr = h; ce = c; d = b;
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 8'd0);
  endtask

  task automatic send4(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] e);
    step(1'b1, 1'b1, a);
    step(1'b1, 1'b1, b);
    step(1'b1, 1'b1, c);
    step(1'b1, 1'b1, e);
  endtask

  task automatic drain_check(input string tag);
    idle(12);
    chk({tag, "_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0) begin
      logic [15:0] e;
      e = exp_q.pop_front();
      if (got_q.size() > 0) chk({tag, "_pix"}, got_q.pop_front(), e);
      else                  chk({tag, "_missing"}, 32'hffff_ffff, e);
    end
    got_q.delete();
    got_cyc_q.delete();
  endtask

  initial begin
    int t0, tv, n1;

    // reset state
    idle(3);
    chk("rst_vsync", o0_vs, 0);
    chk("rst_href",  o0_hr, 0);
    chk("rst_clken", o0_ce, 0);
    chk("rst_rgb",   {o0_r, o0_g, o0_b}, 0);
    chk("rst_rgb1",  {o1_ce, o1_r, o1_g, o1_b}, 0);
    rst_n = 1'b1;
    idle(4);

    // mid-grey
    exp_q.push_back(16'h8410);
    exp_q.push_back(16'h8410);
    send4(8'd128, 8'd128, 8'd128, 8'd128);
    drain_check("grey");

    // overflow clamp with gapped clken; pair must still be on consecutive cycles
    exp_q.push_back(px(31, 30, 31));
    exp_q.push_back(px(31, 30, 31));
    step(1'b1, 1'b1, 8'd255);
    step(1'b1, 1'b0, 8'd7);
    step(1'b1, 1'b1, 8'd255);
    step(1'b1, 1'b1, 8'd255);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b0, 8'd0);
    step(1'b1, 1'b1, 8'd255);
    idle(12);
    if (got_cyc_q.size() == 2) chk("gap_pair_adjacent", got_cyc_q[1] - got_cyc_q[0], 1);
    else                       chk("gap_pair_count", got_cyc_q.size(), 2);
    drain_check("overflow");

    // underflow clamp
    exp_q.push_back(px(0, 33, 0));
    exp_q.push_back(px(0, 33, 0));
    send4(8'd0, 8'd0, 8'd0, 8'd0);
    drain_check("underflow");

    // latency and sync alignment on an 8-byte line
    tv = cyc;
    vs = 1'b1;
    idle(3);
    vs = 1'b0;
    idle(3);
    t0 = cyc;
    send4(8'd128, 8'd128, 8'd128, 8'd128);
    send4(8'd200, 8'd128, 8'd50, 8'd128);
    idle(10);
    if (got_cyc_q.size() == 4) begin
      chk("lat_p0", got_cyc_q[0] - t0, 7);
      chk("lat_p1", got_cyc_q[1] - t0, 8);
      chk("lat_p2", got_cyc_q[2] - t0, 11);
      chk("lat_p3", got_cyc_q[3] - t0, 12);
    end else begin
      chk("lat_count", got_cyc_q.size(), 4);
    end
    for (int n = t0 + 3; n <= t0 + 14; n++)
      chk("href_delay", hr0_h[n], (n >= t0 + 5 && n <= t0 + 12) ? 1 : 0);
    for (int n = tv; n <= tv + 12; n++)
      chk("vsync_delay", vs0_h[n], in_vs_h[n - 5]);
    chk("rgb_hold",  rgb0_h[t0 + 9], 16'h8410);
    chk("rgb_blank", rgb0_h[t0 + 13], 0);
    exp_q.push_back(16'h8410);
    exp_q.push_back(16'h8410);
    exp_q.push_back(px(25, 50, 25));
    exp_q.push_back(px(6, 12, 6));
    drain_check("line8");

    // partial group discarded, then phase restarts at 0
    step(1'b1, 1'b1, 8'd200);
    step(1'b1, 1'b1, 8'd128);
    step(1'b1, 1'b1, 8'd50);
    idle(12);
    chk("partial_none", got_q.size(), 0);
    exp_q.push_back(px(25, 50, 25));
    exp_q.push_back(px(6, 12, 6));
    send4(8'd200, 8'd128, 8'd50, 8'd128);
    drain_check("after_partial");

    // UYVY byte order
    t0 = cyc;
    send4(8'd128, 8'd128, 8'd128, 8'd128);
    idle(10);
    chk("uyvy_ce0",  ce1_h[t0 + 7], 1);
    chk("uyvy_px0",  rgb1_h[t0 + 7], 16'h8410);
    chk("uyvy_ce1",  ce1_h[t0 + 8], 1);
    chk("uyvy_px1",  rgb1_h[t0 + 8], 16'h8410);
    chk("uyvy_ce_n", ce1_h[t0 + 9], 0);

    // reset between the two pixels of a pair
    t0 = cyc;
    send4(8'd128, 8'd128, 8'd128, 8'd128);
    idle(3);
    chk("mid_rst_ce0", o1_ce, 1);
    chk("mid_rst_px0", {o1_r, o1_g, o1_b}, 16'h8410);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 8'd0);
    chk("mid_rst_clr", {o1_vs, o1_hr, o1_ce, o1_r, o1_g, o1_b}, 0);
    chk("mid_rst_href0", o0_hr, 0);
    idle(2);
    rst_n = 1'b1;
    idle(10);
    n1 = 0;
    for (int n = t0 + 8; n < cyc; n++) n1 += int'(ce1_h[n]);
    chk("mid_rst_dropped", n1, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
